avalon_multi_timer: RTL and testbench

Parametrised multi-channel Avalon-MM interval timer: NUM_CH independent down-counters of CNT_W bits, each with its own period, prescaler, compare/PWM output, snapshot, and timeout interrupt. It replaces single-channel 16-bit-bus timers in the SoC. It sits on the system Avalon bus as a slave, driving a per-channel IRQ vector and a combined IRQ to the CPU.

---
 rtl/avalon_multi_timer.sv | 184 ++++++++++++++++++
 tb/tb_avalon_multi_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: NUM_CH independent Avalon-MM interval timers.
// Each channel is a CNT_W-bit down-counter with its own period, 8-bit
// prescaler, compare/PWM output, snapshot register and timeout interrupt.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address               {channel, reg[2:0]}
//   chipselect, write_n   write strobe = chipselect && !write_n
//   writedata             write data (CNT_W fields use the low bits)
//   readdata              registered read data, one cycle latency
//   irq                   OR of irq_vec
//   irq_vec               per-channel TO & ITO
//   pwm_out               per-channel RUN && (count < COMPARE)

module avalon_multi_timer_ch #(
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001_869F
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_status,
    input  logic             wr_control,
    input  logic             wr_period,
    input  logic             wr_compare,
    input  logic             wr_snap,
    input  logic [31:0]      wdata,
    output logic             to,
    output logic             run,
    output logic             ito,
    output logic             cont,
    output logic [7:0]       prescale,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] compare,
    output logic [CNT_W-1:0] snapshot,
    output logic             irq_bit,
    output logic             pwm
);
    logic [CNT_W-1:0] count, cnt_nxt;
    logic [7:0]       psc;
    logic             force_reload;
    logic             nz_d;           // count was nonzero last cycle
    logic             tick, start, stop;

    assign start = wr_control && wdata[2];
    assign stop  = wr_control && wdata[3];
    assign tick  = run && (psc == prescale);

    always_comb begin
        cnt_nxt = count;
        if (force_reload)
            cnt_nxt = period;
        else if (tick)
            cnt_nxt = (count == '0) ? period : count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period       <= DEFAULT_PERIOD[CNT_W-1:0];
            count        <= DEFAULT_PERIOD[CNT_W-1:0];
            compare      <= '0;
            snapshot     <= '0;
            prescale     <= '0;
            ito          <= 1'b0;
            cont         <= 1'b0;
            psc          <= '0;
            run          <= 1'b0;
            to           <= 1'b0;
            nz_d         <= 1'b0;
            force_reload <= 1'b0;
        end else begin
            force_reload <= wr_period;
            if (wr_period)  period  <= wdata[CNT_W-1:0];
            if (wr_compare) compare <= wdata[CNT_W-1:0];
            if (wr_control) begin
                ito      <= wdata[0];
                cont     <= wdata[1];
                prescale <= wdata[15:8];
            end
            if (wr_snap) snapshot <= count;
            count <= cnt_nxt;
            nz_d  <= (count != '0);

            if (start || force_reload || tick) psc <= '0;
            else if (run)                      psc <= psc + 8'd1;

            // One-shot stops on the same edge the counter lands on zero.
            if (start)
                run <= 1'b1;
            else if (stop || force_reload || (tick && cnt_nxt == '0 && !cont))
                run <= 1'b0;

            if (wr_status)
                to <= 1'b0;
            else if (count == '0 && nz_d)
                to <= 1'b1;
        end
    end

    assign irq_bit = to && ito;
    assign pwm     = run && (count < compare);
endmodule

module avalon_multi_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001_869F
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [$clog2(NUM_CH)+2:0] address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      irq,
    output logic [NUM_CH-1:0]         irq_vec,
    output logic [NUM_CH-1:0]         pwm_out
);
    localparam int AW = $clog2(NUM_CH) + 3;

    logic [AW-1:0] ch_sel;
    logic [2:0]    reg_sel;
    logic          ch_ok, wr_en;

    logic [NUM_CH-1:0]            to_r, run_r, ito_r, cont_r;
    logic [NUM_CH-1:0][7:0]       psc_r;
    logic [NUM_CH-1:0][CNT_W-1:0] period_r, compare_r, snap_r;
    logic [31:0]                  rd_nxt;

    assign ch_sel  = address >> 3;
    assign reg_sel = address[2:0];
    assign ch_ok   = (32'(ch_sel) < NUM_CH);
    assign wr_en   = chipselect && !write_n && ch_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && (32'(ch_sel) == i);
        avalon_multi_timer_ch #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .wr_status  (sel && reg_sel == 3'd0),
            .wr_control (sel && reg_sel == 3'd1),
            .wr_period  (sel && reg_sel == 3'd2),
            .wr_compare (sel && reg_sel == 3'd3),
            .wr_snap    (sel && reg_sel == 3'd4),
            .wdata      (writedata),
            .to         (to_r[i]),
            .run        (run_r[i]),
            .ito        (ito_r[i]),
            .cont       (cont_r[i]),
            .prescale   (psc_r[i]),
            .period     (period_r[i]),
            .compare    (compare_r[i]),
            .snapshot   (snap_r[i]),
            .irq_bit    (irq_vec[i]),
            .pwm        (pwm_out[i])
        );
    end

    assign irq = |irq_vec;

    // Read mux is sampled every cycle regardless of chipselect.
    always_comb begin
        rd_nxt = '0;
        if (ch_ok) begin
            case (reg_sel)
                3'd0: rd_nxt = {30'd0, run_r[ch_sel], to_r[ch_sel]};
                3'd1: rd_nxt = {16'd0, psc_r[ch_sel], 6'd0, cont_r[ch_sel], ito_r[ch_sel]};
                3'd2: rd_nxt = 32'(period_r[ch_sel]);
                3'd3: rd_nxt = 32'(compare_r[ch_sel]);
                3'd4: rd_nxt = 32'(snap_r[ch_sel]);
                3'd5: rd_nxt = 32'(irq_vec);
                default: rd_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_nxt;
    end
endmodule

// File: tb/tb_avalon_multi_timer.sv
module tb_avalon_multi_timer;
    localparam int          NUM_CH = 4;
    localparam logic [31:0] DEF    = 32'h0001_869F;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [4:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec, pwm_out;

    avalon_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(32), .DEFAULT_PERIOD(DEF)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0, nchk = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1ns after a rising edge.
    task automatic wr(input int ch, input int r, input logic [31:0] d);
        address = 5'(ch * 8 + r); chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        address = 5'(ch * 8 + r); chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Counts pwm high cycles over w consecutive samples, the first taken now.
    task automatic measure(input int ch, input int w, output int hi);
        hi = 0;
        for (int i = 0; i < w; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            hi += int'(pwm_out[ch]);
        end
    endtask

    task automatic wait_rise(input int ch, input int lim, input string tag, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (irq_vec[ch]) begin t = cyc; break; end
        end
        check(tag, 32'(t >= 0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int t1, t2, hi, ch, per, p, cmp, w, exp_hi;

        #12;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_irq_vec", 32'(irq_vec), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < NUM_CH; c++) begin
            rd(c, 2, d); check($sformatf("rst_period%0d", c), d, DEF);
            rd(c, 0, d); check($sformatf("rst_status%0d", c), d, 32'd0);
        end

        // ch1: continuous, PERIOD=9, prescale 0 -> timeout every 10 clks
        wr(1, 2, 9);
        wr(1, 1, 32'h07);
        wait_rise(1, 30, "ch1_first_to", t1);
        check("ch1_irq", 32'(irq), 32'd1);
        rd(0, 5, d); check("irqvec_rd_ch0", d, 32'h2);
        rd(3, 5, d); check("irqvec_rd_ch3", d, 32'h2);
        check("ch1_others_idle", 32'(irq_vec & 4'hD), 32'd0);
        check("ch1_pwm_idle", 32'(pwm_out), 32'd0);
        wr(1, 0, 0);
        check("ch1_irq_clear", 32'(irq), 32'd0);
        wait_rise(1, 30, "ch1_second_to", t2);
        check("ch1_to_interval", 32'(t2 - t1), 32'd10);
        rd(2, 6, d); check("reg6_zero", d, 32'd0);
        rd(1, 7, d); check("reg7_zero", d, 32'd0);
        wr(1, 1, 32'h08);
        wr(1, 0, 0);
        check("ch1_stopped_irq", 32'(irq), 32'd0);

        // ch2: one-shot PERIOD=4 PRESCALE=3; COMPARE>PERIOD so pwm == RUN.
        // Four decrements at four clks each keep RUN high for 16 clks.
        wr(2, 2, 4);
        wr(2, 3, 8);
        wr(2, 1, 32'h0304);
        measure(2, 30, hi);
        check("ch2_run_clks", 32'(hi), 32'd16);
        rd(2, 0, d); check("ch2_status", d, 32'h1);
        wr(2, 4, 0);
        rd(2, 4, d); check("ch2_count_stays0", d, 32'd0);
        check("ch2_no_irq_ito0", 32'(irq), 32'd0);
        rd(2, 1, d); check("ch2_control_rd", d, 32'h0300);
        wr(2, 0, 0);

        // ch0: PERIOD=99 COMPARE=25 continuous -> 25 of every 100 clks high
        wr(0, 2, 99);
        wr(0, 3, 25);
        wr(0, 1, 32'h06);
        idle(3);
        measure(0, 100, hi);
        check("ch0_pwm_duty", 32'(hi), 32'd25);
        wr(0, 1, 32'h08);
        wr(0, 0, 0);

        // ch3: PERIOD rewrite while running, then START|STOP
        wr(3, 2, 1000);
        wr(3, 1, 32'h06);
        idle(10);
        wr(3, 2, 50);
        idle(1);
        rd(3, 0, d); check("ch3_reload_run0", d, 32'd0);
        wr(3, 4, 0);
        rd(3, 4, d); check("ch3_reload_count", d, 32'd50);
        wr(3, 1, 32'h0C);
        rd(3, 0, d); check("ch3_start_wins", d, 32'h2);

        // Timeout event on the same edge as a STATUS write: write wins.
        wr(3, 2, 20);
        idle(2);
        wr(3, 1, 32'h04);      // one-shot, count 0 after 20 edges
        idle(20);
        wr(3, 0, 0);           // lands on the edge that would set TO
        rd(3, 0, d); check("ch3_to_collision", d, 32'd0);

        // SNAP at count 7 while counting continues
        wr(3, 2, 20);
        idle(2);
        wr(3, 1, 32'h06);
        idle(13);
        wr(3, 4, 0);
        idle(5);
        rd(3, 4, d); check("ch3_snap7", d, 32'd7);
        rd(3, 0, d); check("ch3_still_running", d, 32'h2);
        idle(30);
        rd(3, 4, d); check("ch3_snap7_held", d, 32'd7);
        wr(3, 1, 32'h08);
        wr(3, 0, 0);

        // Randomized channels checked against the period/duty formulas
        for (int it = 0; it < 6; it++) begin
            ch  = int'($urandom_range(0, NUM_CH - 1));
            per = int'($urandom_range(5, 40));
            p   = int'($urandom_range(0, 3));
            cmp = int'($urandom_range(0, per + 3));
            w   = (per + 1) * (p + 1);
            exp_hi = ((cmp < per + 1) ? cmp : per + 1) * (p + 1);
            wr(ch, 2, 32'(per));
            wr(ch, 3, 32'(cmp));
            wr(ch, 1, 32'((p << 8) | 7));
            rd(ch, 3, d); check($sformatf("rnd%0d_compare", it), d, 32'(cmp));
            rd(ch, 1, d); check($sformatf("rnd%0d_control", it), d, 32'((p << 8) | 3));
            rd(ch, 2, d); check($sformatf("rnd%0d_period", it), d, 32'(per));
            idle(w);
            measure(ch, w, hi);
            check($sformatf("rnd%0d_duty", it), 32'(hi), 32'(exp_hi));
            wr(ch, 0, 0);
            wait_rise(ch, 2 * w + 5, $sformatf("rnd%0d_to_a", it), t1);
            wr(ch, 0, 0);
            wait_rise(ch, 2 * w + 5, $sformatf("rnd%0d_to_b", it), t2);
            check($sformatf("rnd%0d_interval", it), 32'(t2 - t1), 32'(w));
            check($sformatf("rnd%0d_isolation", it), 32'(irq_vec & ~(4'(1) << ch)), 32'd0);
            wr(ch, 1, 32'h08);
            wr(ch, 0, 0);
            check($sformatf("rnd%0d_irq_off", it), 32'(irq), 32'd0);
            check($sformatf("rnd%0d_pwm_off", it), 32'(pwm_out), 32'd0);
        end

        // Asynchronous reset mid-count
        wr(0, 2, 30);
        wr(0, 3, 40);
        wr(0, 1, 32'h07);
        idle(5);
        check("arst_pre_pwm", 32'(pwm_out[0]), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm_out), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_readdata", readdata, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        rd(0, 2, d); check("arst_period", d, DEF);
        rd(0, 1, d); check("arst_control", d, 32'd0);
        rd(0, 3, d); check("arst_compare", d, 32'd0);
        rd(0, 0, d); check("arst_status", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
